// File: rtl/adc_serial_responder.sv
// adc_serial_responder
// ADC end of a CONVST/SCK/SDI/SDO serial link. Samples one of eight parallel
// channel values on CONVST, holds busy for the conversion time, then shifts
// the result out MSB-first on SDO while capturing a 6-bit config word from SDI.
//
// Optional build macro: ADC_RESP_OVERRUN_EN
//   defined   -> sticky overrun flag for CONVST arriving mid-conversion or
//                before the full result has been shifted out
//   undefined -> overrun tied low, no detection logic
//
// state | meaning
// IDLE  | after reset, waiting for the first CONVST rise; SCK/SDI ignored
// CONV  | busy time counting down; SCK and CONVST edges ignored
// READ  | result on SDO (advances per SCK fall), config sampled per SCK rise
`timescale 1ns/1ps

module adc_serial_responder #(
   parameter int DATA_W      = 12,
   parameter int CONV_CYCLES = 80,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  adc_convst,
   input  logic                  adc_sck,
   input  logic                  adc_sdi,
   output logic                  adc_sdo,
   input  logic [8*DATA_W-1:0]   chan_data,
   output logic                  busy,
   output logic [5:0]            cfg_word,
   output logic                  cfg_valid,
   output logic                  overrun
);

   localparam int CNT_W  = (CONV_CYCLES > 2) ? $clog2(CONV_CYCLES) : 1;
   localparam int FALL_W = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0]  BUSY_LOAD = CNT_W'(CONV_CYCLES - 1);
   localparam logic [FALL_W-1:0] FALL_MAX  = FALL_W'(DATA_W);
   localparam logic [5:0]        CFG_RESET = 6'b100010;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CONV = 2'd1,
      ST_READ = 2'd2
   } state_t;

   logic [SYNC_STAGES-1:0] convst_sync_q;
   logic [SYNC_STAGES-1:0] sck_sync_q;
   logic [SYNC_STAGES-1:0] sdi_sync_q;
   logic                   convst_prev_q;
   logic                   sck_prev_q;

   logic                   convst_s;
   logic                   sck_s;
   logic                   sdi_s;
   logic                   convst_rise;
   logic                   sck_rise;
   logic                   sck_fall;

   state_t                 state_q;
   logic [CNT_W-1:0]       busy_cnt_q;
   logic [DATA_W-1:0]      shift_q;
   logic [DATA_W-1:0]      snap_d;
   logic [FALL_W-1:0]      fall_cnt_q;
   logic [2:0]             rise_cnt_q;
   logic [4:0]             cfg_shift_q;
   logic [5:0]             cfg_word_q;
   logic                   sdo_q;
   logic                   busy_q;
   logic                   cfg_valid_q;
   logic [2:0]             sel;

   // Bring the initiator's asynchronous link signals into the clk domain.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         convst_sync_q <= '0;
         sck_sync_q    <= '0;
         sdi_sync_q    <= '0;
         convst_prev_q <= 1'b0;
         sck_prev_q    <= 1'b0;
      end else begin
         convst_sync_q[0] <= adc_convst;
         sck_sync_q[0]    <= adc_sck;
         sdi_sync_q[0]    <= adc_sdi;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            convst_sync_q[i] <= convst_sync_q[i-1];
            sck_sync_q[i]    <= sck_sync_q[i-1];
            sdi_sync_q[i]    <= sdi_sync_q[i-1];
         end
         convst_prev_q <= convst_sync_q[SYNC_STAGES-1];
         sck_prev_q    <= sck_sync_q[SYNC_STAGES-1];
      end
   end

   assign convst_s    = convst_sync_q[SYNC_STAGES-1];
   assign sck_s       = sck_sync_q[SYNC_STAGES-1];
   assign sdi_s       = sdi_sync_q[SYNC_STAGES-1];
   assign convst_rise = convst_s & ~convst_prev_q;
   assign sck_rise    = sck_s & ~sck_prev_q;
   assign sck_fall    = ~sck_s & sck_prev_q;

   // Channel snapshot for the next conversion. sel = {S1, S0, O/S}; S/D is
   // not modelled (differential reads the same channel). UNI=0 flips the MSB
   // to turn straight binary into two's complement.
   always_comb begin
      sel    = {cfg_word_q[3], cfg_word_q[2], cfg_word_q[4]};
      snap_d = chan_data[int'(sel)*DATA_W +: DATA_W];
      if (!cfg_word_q[1]) begin
         snap_d[DATA_W-1] = ~snap_d[DATA_W-1];
      end
   end

   // Link FSM: conversion timing, result shift-out and config capture.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         busy_cnt_q  <= '0;
         shift_q     <= '0;
         fall_cnt_q  <= '0;
         rise_cnt_q  <= '0;
         cfg_shift_q <= '0;
         cfg_word_q  <= CFG_RESET;
         sdo_q       <= 1'b0;
         busy_q      <= 1'b0;
         cfg_valid_q <= 1'b0;
      end else begin
         cfg_valid_q <= 1'b0;
         // A CONVST rise outside CONV always starts a fresh conversion; any
         // partially received config word is simply dropped with the counters.
         if (convst_rise && (state_q != ST_CONV)) begin
            state_q     <= ST_CONV;
            busy_q      <= 1'b1;
            busy_cnt_q  <= BUSY_LOAD;
            shift_q     <= snap_d;
            sdo_q       <= 1'b0;
            fall_cnt_q  <= '0;
            rise_cnt_q  <= '0;
            cfg_shift_q <= '0;
         end else begin
            case (state_q)
               ST_IDLE: begin
               end
               ST_CONV: begin
                  if (busy_cnt_q == '0) begin
                     state_q <= ST_READ;
                     busy_q  <= 1'b0;
                     sdo_q   <= shift_q[DATA_W-1];
                     shift_q <= {shift_q[DATA_W-2:0], 1'b0};
                  end else begin
                     busy_cnt_q <= busy_cnt_q - 1'b1;
                  end
               end
               ST_READ: begin
                  if (sck_fall) begin
                     if (fall_cnt_q < FALL_MAX) begin
                        sdo_q      <= shift_q[DATA_W-1];
                        shift_q    <= {shift_q[DATA_W-2:0], 1'b0};
                        fall_cnt_q <= fall_cnt_q + 1'b1;
                     end else begin
                        sdo_q <= 1'b0;
                     end
                  end
                  if (sck_rise && (rise_cnt_q < 3'd6)) begin
                     cfg_shift_q <= {cfg_shift_q[3:0], sdi_s};
                     rise_cnt_q  <= rise_cnt_q + 1'b1;
                     if (rise_cnt_q == 3'd5) begin
                        cfg_word_q  <= {cfg_shift_q, sdi_s};
                        cfg_valid_q <= 1'b1;
                     end
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

`ifdef ADC_RESP_OVERRUN_EN
   logic overrun_q;

   // Sticky flag: CONVST while converting, or before the full result left SDO.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overrun_q <= 1'b0;
      end else if (convst_rise &&
                   ((state_q == ST_CONV) ||
                    ((state_q == ST_READ) && (fall_cnt_q < FALL_MAX)))) begin
         overrun_q <= 1'b1;
      end
   end

   assign overrun = overrun_q;
`else
   assign overrun = 1'b0;
`endif

   assign adc_sdo   = sdo_q;
   assign busy      = busy_q;
   assign cfg_word  = cfg_word_q;
   assign cfg_valid = cfg_valid_q;

endmodule

// File: tb/tb_adc_serial_responder.sv
// Scoreboard bench for adc_serial_responder: stimulus pushes expected busy
// lengths, SDO frames and config words; monitors pop and compare.
`timescale 1ns/1ps

module tb_adc_serial_responder;

   logic         clk;
   logic         reset_n;
   logic         adc_convst;
   logic         adc_sck;
   logic         adc_sdi;
   logic         adc_sdo;
   logic [95:0]  chan_data;
   logic         busy;
   logic [5:0]   cfg_word;
   logic         cfg_valid;
   logic         overrun;

   int n_checks = 0;
   int n_pass   = 0;

   logic [11:0] exp_frame_q[$];
   logic [5:0]  exp_cfg_q[$];
   int          exp_busy_q[$];

   int          mon_bits = 0;
   logic [11:0] mon_word = '0;
   int          busy_len = 0;
   logic        exp_ovr;

   adc_serial_responder #(
      .DATA_W      (12),
      .CONV_CYCLES (80),
      .SYNC_STAGES (2)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .adc_convst (adc_convst),
      .adc_sck    (adc_sck),
      .adc_sdi    (adc_sdi),
      .adc_sdo    (adc_sdo),
      .chan_data  (chan_data),
      .busy       (busy),
      .cfg_word   (cfg_word),
      .cfg_valid  (cfg_valid),
      .overrun    (overrun)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // SDO monitor: collects 12 bits at SCK rises after each CONVST rise.
   always @(posedge adc_sck or posedge adc_convst or negedge reset_n) begin
      if (!reset_n || adc_convst) begin
         mon_bits = 0;
         mon_word = '0;
      end else if (mon_bits < 12) begin
         mon_word = {mon_word[10:0], adc_sdo};
         mon_bits++;
         if (mon_bits == 12) begin
            check("frame_expected", int'(exp_frame_q.size() != 0), 1);
            if (exp_frame_q.size() != 0) check("sdo_frame", mon_word, exp_frame_q.pop_front());
         end
      end
   end

   // Config and busy-length monitor.
   always @(negedge clk) begin
      if (reset_n === 1'b1 && cfg_valid === 1'b1) begin
         check("cfg_expected", int'(exp_cfg_q.size() != 0), 1);
         if (exp_cfg_q.size() != 0) check("cfg_word", cfg_word, exp_cfg_q.pop_front());
      end
      if (reset_n !== 1'b1) begin
         busy_len = 0;
      end else if (busy === 1'b1) begin
         busy_len++;
      end else if (busy_len != 0) begin
         check("busy_expected", int'(exp_busy_q.size() != 0), 1);
         if (exp_busy_q.size() != 0) check("busy_len", busy_len, exp_busy_q.pop_front());
         busy_len = 0;
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic convst_pulse();
      @(negedge clk);
      adc_convst = 1'b1;
      repeat (4) @(negedge clk);
      adc_convst = 1'b0;
   endtask

   task automatic wait_conv_done();
      int k = 0;
      while (busy === 1'b1 && k < 300) begin
         @(negedge clk);
         k++;
      end
      check("busy_release", int'(busy), 0);
      repeat (2) @(negedge clk);
   endtask

   task automatic sck_burst(input int n, input logic [5:0] sdi_bits);
      for (int i = 0; i < n; i++) begin
         adc_sdi = (i < 6) ? sdi_bits[5-i] : 1'b0;
         repeat (4) @(negedge clk);
         adc_sck = 1'b1;
         repeat (4) @(negedge clk);
         adc_sck = 1'b0;
      end
      adc_sdi = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic frame(input logic [11:0] exp_data, input logic [5:0] sdi_bits);
      exp_busy_q.push_back(80);
      exp_frame_q.push_back(exp_data);
      exp_cfg_q.push_back(sdi_bits);
      convst_pulse();
      wait_conv_done();
      sck_burst(12, sdi_bits);
   endtask

   initial begin
`ifdef ADC_RESP_OVERRUN_EN
      exp_ovr = 1'b1;
`else
      exp_ovr = 1'b0;
`endif
      reset_n    = 1'b0;
      adc_convst = 1'b0;
      adc_sck    = 1'b0;
      adc_sdi    = 1'b0;
      chan_data  = {12'h709, 12'h6F8, 12'h5E7, 12'h4D6,
                    12'h3C5, 12'h2B4, 12'h123, 12'hA5C};

      // 1: reset values
      repeat (5) @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_sdo", int'(adc_sdo), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_cfg_word", cfg_word, 6'b100010);
      check("rst_cfg_valid", int'(cfg_valid), 0);
      check("rst_overrun", int'(overrun), 0);

      // 2: CH0 unipolar, new config selects CH1
      frame(12'hA5C, 6'b110010);
      check("sdo_after_12", int'(adc_sdo), 0);
      check("cfg_word_f2", cfg_word, 6'b110010);

      // 3: CH1 from previous frame's config
      frame(12'h123, 6'b110010);

      // 4: bipolar config applies one frame later
      frame(12'h123, 6'b110000);
      frame(12'h923, 6'b110000);
      check("overrun_clean", int'(overrun), 0);

      // 5: abort after 5 SCK cycles
      exp_busy_q.push_back(80);
      convst_pulse();
      wait_conv_done();
      sck_burst(5, 6'b100010);
      exp_busy_q.push_back(80);
      convst_pulse();
      check("abort_busy", int'(busy), 1);
      check("abort_cfg_word", cfg_word, 6'b110000);
      check("abort_overrun", int'(overrun), int'(exp_ovr));
      wait_conv_done();

      // 6: reset mid-conversion
      convst_pulse();
      repeat (36) @(negedge clk);
      check("mid_conv_busy", int'(busy), 1);
      reset_n = 1'b0;
      #1;
      check("rst_async_busy", int'(busy), 0);
      check("rst_async_sdo", int'(adc_sdo), 0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      check("rst2_cfg_word", cfg_word, 6'b100010);
      check("rst2_overrun", int'(overrun), 0);
      exp_frame_q.push_back(12'h000);
      sck_burst(16, 6'b111111);
      check("idle_sdo", int'(adc_sdo), 0);
      check("idle_busy", int'(busy), 0);

      repeat (5) @(negedge clk);
      check("frames_left", exp_frame_q.size(), 0);
      check("cfg_left", exp_cfg_q.size(), 0);
      check("busy_left", exp_busy_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
